rd_fwft_ctrl: RTL and testbench

- Read-side consumer for the async FIFO, in the rclk domain.
- Pulls words out of the FIFO by driving rinc against rempty from the read-pointer/empty logic, and captures the registered memory read data.
- Presents the words to downstream logic as a first-word-fall-through valid/ready stream.
- A 2-entry output buffer plus one in-flight read sustain 1 word/cycle under continuous out_ready and never overrun under backpressure.

---
 rtl/rd_fwft_ctrl.sv | 82 ++++++++
 tb/tb_rd_fwft_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rd_fwft_ctrl.sv
// rtl/rd_fwft_ctrl.sv - async FIFO read-side consumer presenting a first-word-fall-through stream
module rd_fwft_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            buf_level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    buf_state_t            state;
    buf_state_t            state_nxt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] entry [2];
    logic                  head;
    logic                  tail;
    logic                  out_fire;
    logic [2:0]            occ_after;

    // Occupancy after this edge's fire, counting the read already in flight;
    // popping only below 2 guarantees the returning word always has a slot.
    always_comb begin
        out_fire  = out_valid & out_ready;
        occ_after = {1'b0, state} + {2'b00, inflight} - {2'b00, out_fire};
        rinc      = ~rempty & (occ_after < 3'd2);
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (inflight) state_nxt = ONE;
            end
            ONE: begin
                if (inflight & ~out_fire)      state_nxt = TWO;
                else if (~inflight & out_fire) state_nxt = EMPTY;
            end
            TWO: begin
                if (~inflight & out_fire) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            inflight  <= 1'b0;
            head      <= 1'b0;
            tail      <= 1'b0;
            entry[0]  <= '0;
            entry[1]  <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            inflight  <= rinc;
            if (inflight) begin
                entry[tail] <= mem_rdata;
                tail        <= ~tail;
            end
            if (out_fire) begin
                head <= ~head;
            end
        end
    end

    assign out_data  = entry[head];
    assign buf_level = state;

    a_no_overrun: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(inflight && state == TWO && !out_fire));

endmodule

// File: tb/tb_rd_fwft_ctrl.sv
// tb/tb_rd_fwft_ctrl.sv - directed-vector bench for rd_fwft_ctrl
module tb_rd_fwft_ctrl;
    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rempty;
    logic          rinc;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    buf_level;

    logic [7:0]    mem [64];
    logic [5:0]    rd_ptr;
    logic [5:0]    wr_ptr = '0;
    logic          hold_empty = 1'b0;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    logic [7:0]    rx_q [$];
    int            rx_cyc [$];
    int            rinc_cnt = 0;
    int            viol_cnt = 0;
    int            stab_err = 0;
    int            max_lvl = 0;
    logic          prev_hold = 1'b0;
    logic [7:0]    prev_data = '0;

    rd_fwft_ctrl #(.DATA_WIDTH(DW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rinc      (rinc),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .buf_level (buf_level)
    );

    always #5 rclk = ~rclk;

    // FIFO source: registered memory read, pointer reset on the shared rrst_n
    assign rempty = (rd_ptr == wr_ptr) | hold_empty;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_ptr    <= '0;
            mem_rdata <= '0;
        end else if (rinc) begin
            mem_rdata <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    always @(negedge rclk) begin
        cyc = cyc + 1;
        if (rrst_n) begin
            if (rinc) rinc_cnt = rinc_cnt + 1;
            if (rinc && rempty) viol_cnt = viol_cnt + 1;
            if (int'(buf_level) > max_lvl) max_lvl = int'(buf_level);
            if (prev_hold && out_data != prev_data) stab_err = stab_err + 1;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rx_cyc.push_back(cyc);
            end
            prev_hold = out_valid & ~out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        if (obs !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        rinc_cnt = 0;
        viol_cnt = 0;
        stab_err = 0;
        max_lvl  = 0;
    endtask

    task automatic push(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + i[7:0];
            wr_ptr      = wr_ptr + 6'd1;
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] base, input int n, input bit gapless);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(rx_q[i]), 32'(base) + 32'(i));
        end
        if (gapless && rx_q.size() == n) begin
            check({tag, "_gapless"}, 32'(rx_cyc[n-1] - rx_cyc[0]), 32'(n - 1));
        end
    endtask

    initial begin
        step(2);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_level", 32'(buf_level), 0);
        check("rst_rinc", 32'(rinc), 0);
        rrst_n = 1'b1;
        step(1);

        // single word: pop in cycle 0, visible in cycle 2
        clear_mon();
        out_ready = 1'b1;
        push(8'hA5, 1);
        #1;
        check("t1_rinc_c0", 32'(rinc), 1);
        check("t1_valid_c0", 32'(out_valid), 0);
        step(1);
        check("t1_valid_c1", 32'(out_valid), 0);
        check("t1_rinc_c1", 32'(rinc), 0);
        step(1);
        check("t1_valid_c2", 32'(out_valid), 1);
        check("t1_data_c2", 32'(out_data), 32'hA5);
        step(1);
        check("t1_level_c3", 32'(buf_level), 0);
        check("t1_valid_c3", 32'(out_valid), 0);
        check_rx("t1", 8'hA5, 1, 1'b0);

        // streaming at one word per cycle
        clear_mon();
        push(8'h00, 16);
        step(24);
        check_rx("t2", 8'h00, 16, 1'b1);

        // backpressure: only two pops, head held stable
        clear_mon();
        out_ready = 1'b0;
        push(8'h30, 5);
        step(8);
        check("t3_rinc_cnt", 32'(rinc_cnt), 2);
        check("t3_level", 32'(buf_level), 2);
        check("t3_rinc_idle", 32'(rinc), 0);
        check("t3_valid", 32'(out_valid), 1);
        check("t3_head", 32'(out_data), 32'h30);
        out_ready = 1'b1;
        step(12);
        check_rx("t3", 8'h30, 5, 1'b1);
        check("t3_stable", 32'(stab_err), 0);

        // ready toggling
        clear_mon();
        push(8'h40, 8);
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 2 == 0);
            step(1);
        end
        out_ready = 1'b1;
        step(4);
        check_rx("t4", 8'h40, 8, 1'b0);
        check("t4_lvl_le2", 32'(max_lvl <= 2), 1);
        check("t4_stable", 32'(stab_err), 0);

        // empty flag flickering every cycle
        clear_mon();
        push(8'h50, 6);
        for (int i = 0; i < 24; i++) begin
            hold_empty = (i % 2 == 1);
            step(1);
        end
        hold_empty = 1'b0;
        step(4);
        check_rx("t5", 8'h50, 6, 1'b0);
        check("t5_rinc_vs_empty", 32'(viol_cnt), 0);
        check("t5_rinc_cnt", 32'(rinc_cnt), 6);

        // reset with a buffered word and a read in flight
        clear_mon();
        out_ready = 1'b0;
        push(8'h60, 5);
        step(2);
        check("t6_pre_level", 32'(buf_level), 1);
        #2;
        rrst_n = 1'b0;
        wr_ptr = '0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_level", 32'(buf_level), 0);
        check("t6_rst_rinc", 32'(rinc), 0);
        check("t6_rst_data", 32'(out_data), 0);
        step(2);
        rrst_n = 1'b1;
        clear_mon();
        out_ready = 1'b1;
        push(8'h77, 1);
        step(6);
        check_rx("t6", 8'h77, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
